// File: rtl/i2c_byte_sequencer_pkg.sv
// Shared widths, sequencer state type and FIFO sizing helper for the
// I2C byte sequencer.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_START   = 3'd1,
    SEQ_WAIT_TX = 3'd2,
    SEQ_XFER    = 3'd3,
    SEQ_STOP    = 3'd4,
    SEQ_DONE    = 3'd5
  } i2c_seq_state_t;

  // Power-of-two FIFO pointers carry one extra wrap bit.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/i2c_byte_sequencer_if.sv
// Command, TX/RX stream, status and master-side signals of the byte sequencer.
interface i2c_byte_sequencer_if #(
  parameter int LEN_W = 8
);
  import i2c_pkg::*;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [I2C_ADDR_W-1:0] cmd_addr_i;
  logic                  cmd_rw_i;
  logic [LEN_W-1:0]      cmd_len_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [I2C_BYTE_W-1:0] tx_data_i;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic [I2C_BYTE_W-1:0] rx_data_o;
  logic                  done_o;
  logic                  nack_o;
  logic                  mst_enable_o;
  logic [I2C_ADDR_W-1:0] mst_addr_o;
  logic                  mst_rw_o;
  logic [I2C_BYTE_W-1:0] mst_wdata_o;
  logic                  mst_eow_o;
  logic                  mst_ack_o;
  logic                  mst_byte_done_i;
  logic [I2C_BYTE_W-1:0] mst_rdata_i;
  logic                  mst_slave_nack_i;
  logic                  mst_busy_i;

  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_rw_i, cmd_len_i,
    input  tx_valid_i, tx_data_i, rx_ready_i,
    input  mst_byte_done_i, mst_rdata_i, mst_slave_nack_i, mst_busy_i,
    output cmd_ready_o, tx_ready_o, rx_valid_o, rx_data_o, done_o, nack_o,
    output mst_enable_o, mst_addr_o, mst_rw_o, mst_wdata_o, mst_eow_o, mst_ack_o
  );

  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_rw_i, cmd_len_i,
    output tx_valid_i, tx_data_i, rx_ready_i,
    output mst_byte_done_i, mst_rdata_i, mst_slave_nack_i, mst_busy_i,
    input  cmd_ready_o, tx_ready_o, rx_valid_o, rx_data_o, done_o, nack_o,
    input  mst_enable_o, mst_addr_o, mst_rw_o, mst_wdata_o, mst_eow_o, mst_ack_o
  );
endinterface

// File: rtl/i2c_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; push gated by not-full,
// pop gated by not-empty, head presented combinationally.
module i2c_byte_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [I2C_BYTE_W-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [I2C_BYTE_W-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [I2C_BYTE_W-1:0] mem_r [DEPTH];
  logic                  push_s;
  logic                  pop_s;

  assign full_o     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_o    = (wr_ptr_r == rd_ptr_r);
  assign push_s     = push_i && !full_o;
  assign pop_s      = pop_i && !empty_o;
  assign pop_data_o = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data_i;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/i2c_byte_sequencer.sv
// Feeds the I2C master one byte at a time from a TX FIFO, gathers read
// bytes into an RX FIFO and reports completion / slave-NACK status.
module i2c_byte_sequencer
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  i2c_byte_sequencer_if.slave bus
);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  i2c_seq_state_t        state_r;
  i2c_seq_state_t        state_s;
  logic [I2C_ADDR_W-1:0] addr_r;
  logic                  rw_r;
  logic [LEN_W-1:0]      remaining_r;
  logic [LEN_W-1:0]      flush_cnt_r;
  logic [I2C_BYTE_W-1:0] wdata_r;
  logic                  enable_r;
  logic                  nack_r;
  logic                  underrun_r;

  logic accept_s, launch_s, byte_load_s, set_underrun_s, rx_push_s, rx_ovf_s;
  logic dec_s, abort_s, wdata_load_s, flush_pop_s, tx_pop_s, set_nack_s, last_s;
  logic tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [I2C_BYTE_W-1:0] tx_head_s;
  logic [I2C_BYTE_W-1:0] rx_head_s;

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (bus.tx_valid_i),
    .push_data_i (bus.tx_data_i),
    .pop_i       (tx_pop_s),
    .pop_data_o  (tx_head_s),
    .full_o      (tx_full_s),
    .empty_o     (tx_empty_s)
  );

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (rx_push_s),
    .push_data_i (bus.mst_rdata_i),
    .pop_i       (bus.rx_ready_i),
    .pop_data_o  (rx_head_s),
    .full_o      (rx_full_s),
    .empty_o     (rx_empty_s)
  );

  assign last_s = (remaining_r == LEN_ONE);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= SEQ_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_s        = state_r;
    accept_s       = 1'b0;
    launch_s       = 1'b0;
    byte_load_s    = 1'b0;
    set_underrun_s = 1'b0;
    rx_push_s      = 1'b0;
    rx_ovf_s       = 1'b0;
    dec_s          = 1'b0;
    abort_s        = 1'b0;
    case (state_r)
      SEQ_IDLE: begin
        if (bus.cmd_valid_i) begin
          accept_s = 1'b1;
          state_s  = (bus.cmd_len_i == '0) ? SEQ_DONE : SEQ_START;
        end else begin
          state_s = SEQ_IDLE;
        end
      end
      SEQ_START, SEQ_WAIT_TX: begin
        if (bus.mst_slave_nack_i) begin
          abort_s = 1'b1;
          state_s = SEQ_STOP;
        end else if (!rw_r && tx_empty_s) begin
          state_s = SEQ_WAIT_TX;
        end else begin
          launch_s = 1'b1;
          state_s  = SEQ_XFER;
        end
      end
      SEQ_XFER: begin
        if (bus.mst_slave_nack_i) begin
          abort_s = 1'b1;
          state_s = SEQ_STOP;
        end else if (bus.mst_byte_done_i) begin
          dec_s = 1'b1;
          if (rw_r) begin
            rx_push_s = !rx_full_s;
            rx_ovf_s  = rx_full_s;
          end else if (!last_s && !underrun_r) begin
            byte_load_s    = !tx_empty_s;
            set_underrun_s = tx_empty_s;
          end else begin
            byte_load_s = 1'b0;
          end
          // After an underrun the master stops on the byte it already holds.
          state_s = (last_s || underrun_r) ? SEQ_STOP : SEQ_XFER;
        end else begin
          state_s = SEQ_XFER;
        end
      end
      SEQ_STOP: begin
        if (!bus.mst_busy_i && (flush_cnt_r == '0)) begin
          state_s = SEQ_DONE;
        end else begin
          state_s = SEQ_STOP;
        end
      end
      SEQ_DONE: state_s = SEQ_IDLE;
      default:  state_s = SEQ_IDLE;
    endcase
  end

  assign wdata_load_s = (launch_s && !rw_r) || byte_load_s;
  assign flush_pop_s  = (flush_cnt_r != '0) && !tx_empty_s;
  assign tx_pop_s     = wdata_load_s || flush_pop_s;
  assign set_nack_s   = rx_ovf_s || set_underrun_s ||
                        (bus.mst_slave_nack_i && (state_r != SEQ_IDLE));

  // Command latch, byte counter, write data and status flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_r      <= '0;
      rw_r        <= 1'b0;
      remaining_r <= '0;
      wdata_r     <= '0;
      enable_r    <= 1'b0;
      nack_r      <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      enable_r <= launch_s;
      if (accept_s) begin
        addr_r      <= bus.cmd_addr_i;
        rw_r        <= bus.cmd_rw_i;
        remaining_r <= bus.cmd_len_i;
        nack_r      <= 1'b0;
        underrun_r  <= 1'b0;
      end else begin
        if (abort_s || (dec_s && underrun_r)) begin
          remaining_r <= '0;
        end else if (dec_s) begin
          remaining_r <= remaining_r - LEN_ONE;
        end
        if (wdata_load_s) begin
          wdata_r <= tx_head_s;
        end
        if (set_underrun_s) begin
          underrun_r <= 1'b1;
        end else if (state_r == SEQ_DONE) begin
          underrun_r <= 1'b0;
        end
        if (set_nack_s) begin
          nack_r <= 1'b1;
        end
      end
    end
  end

  // TX flush after a slave NACK; the byte already in wdata_r is not counted
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flush_cnt_r <= '0;
    end else if (abort_s) begin
      if (rw_r) begin
        flush_cnt_r <= '0;
      end else if (state_r == SEQ_XFER) begin
        flush_cnt_r <= remaining_r - LEN_ONE;
      end else begin
        flush_cnt_r <= remaining_r;
      end
    end else if (flush_pop_s) begin
      flush_cnt_r <= flush_cnt_r - LEN_ONE;
    end else if (tx_empty_s) begin
      flush_cnt_r <= '0;
    end
  end

  assign bus.cmd_ready_o  = (state_r == SEQ_IDLE);
  assign bus.tx_ready_o   = !tx_full_s;
  assign bus.rx_valid_o   = !rx_empty_s;
  assign bus.rx_data_o    = rx_head_s;
  assign bus.done_o       = (state_r == SEQ_DONE);
  assign bus.nack_o       = nack_r;
  assign bus.mst_enable_o = enable_r;
  assign bus.mst_addr_o   = addr_r;
  assign bus.mst_rw_o     = rw_r;
  assign bus.mst_wdata_o  = wdata_r;
  assign bus.mst_eow_o    = (!rw_r && last_s) || underrun_r;
  assign bus.mst_ack_o    = !(rw_r && last_s);
endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Randomized bench for i2c_byte_sequencer: a small master model answers each
// transfer while byte queues hold the data the sequencer must reproduce.
module tb_i2c_byte_sequencer;
  import i2c_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   en_cnt   = 0;
  int   done_cnt = 0;

  i2c_byte_sequencer_if #(.LEN_W(LW)) bus ();

  i2c_byte_sequencer #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mst_enable_o) en_cnt <= en_cnt + 1;
    if (bus.done_o) done_cnt <= done_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [I2C_BYTE_W-1:0] d);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = d;
    cycle(1);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic rw, input logic [7:0] len);
    check_val("cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = a;
    bus.cmd_rw_i    = rw;
    bus.cmd_len_i   = len;
    cycle(1);
    bus.cmd_valid_i = 1'b0;
  endtask

  // Cycles from the accepting edge until mst_enable_o is seen; 99 if never.
  task automatic wait_enable(output int lat);
    bit found;
    found = 1'b0;
    lat   = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mst_enable_o) found = 1'b1;
      else begin
        cycle(1);
        lat++;
      end
    end
    if (!found) lat = 99;
  endtask

  task automatic pulse_byte_done(input logic [I2C_BYTE_W-1:0] d);
    bus.mst_rdata_i     = d;
    bus.mst_byte_done_i = 1'b1;
    cycle(1);
    bus.mst_byte_done_i = 1'b0;
  endtask

  task automatic end_xfer(input string tag);
    bit seen;
    cycle($urandom_range(1, 3));
    bus.mst_busy_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus.done_o) seen = 1'b1;
      else cycle(1);
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    cycle(1);
    check_val({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
    check_val({tag, "_tx_ready"},  32'(bus.tx_ready_o),  32'd1);
    check_val({tag, "_rx_valid"},  32'(bus.rx_valid_o),  32'd0);
    check_val({tag, "_done"},      32'(bus.done_o),      32'd0);
    check_val({tag, "_nack"},      32'(bus.nack_o),      32'd0);
    check_val({tag, "_enable"},    32'(bus.mst_enable_o), 32'd0);
    check_val({tag, "_eow"},       32'(bus.mst_eow_o),   32'd0);
    check_val({tag, "_ack"},       32'(bus.mst_ack_o),   32'd1);
    check_val({tag, "_wdata"},     32'(bus.mst_wdata_o), 32'd0);
    check_val({tag, "_addr"},      32'(bus.mst_addr_o),  32'd0);
    check_val({tag, "_rw"},        32'(bus.mst_rw_o),    32'd0);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [I2C_BYTE_W-1:0] data_q[$]);
    int n, e0, d0, lat;
    n  = data_q.size();
    e0 = en_cnt;
    d0 = done_cnt;
    foreach (data_q[i]) push_tx(data_q[i]);
    send_cmd(a, 1'b0, 8'(n));
    wait_enable(lat);
    check_val("wr_latency", 32'(lat), 32'd2);
    check_val("wr_addr", 32'(bus.mst_addr_o), 32'(a));
    check_val("wr_rw", 32'(bus.mst_rw_o), 32'd0);
    bus.mst_busy_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 2));
      check_val("wr_data", 32'(bus.mst_wdata_o), 32'(data_q[i]));
      check_val("wr_eow", 32'(bus.mst_eow_o), 32'(i == n - 1));
      check_val("wr_ack", 32'(bus.mst_ack_o), 32'd1);
      pulse_byte_done(8'h00);
    end
    end_xfer("wr");
    check_val("wr_nack", 32'(bus.nack_o), 32'd0);
    check_val("wr_enables", 32'(en_cnt - e0), 32'd1);
    check_val("wr_dones", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic do_read(input logic [6:0] a, input logic [I2C_BYTE_W-1:0] data_q[$]);
    int n, e0, lat;
    n  = data_q.size();
    e0 = en_cnt;
    send_cmd(a, 1'b1, 8'(n));
    wait_enable(lat);
    check_val("rd_latency", 32'(lat), 32'd2);
    check_val("rd_addr", 32'(bus.mst_addr_o), 32'(a));
    check_val("rd_rw", 32'(bus.mst_rw_o), 32'd1);
    bus.mst_busy_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 2));
      check_val("rd_ack", 32'(bus.mst_ack_o), 32'(i != n - 1));
      check_val("rd_eow", 32'(bus.mst_eow_o), 32'd0);
      pulse_byte_done(data_q[i]);
    end
    end_xfer("rd");
    check_val("rd_nack", 32'(bus.nack_o), 32'd0);
    check_val("rd_enables", 32'(en_cnt - e0), 32'd1);
    for (int i = 0; i < n; i++) begin
      check_val("rd_rx_valid", 32'(bus.rx_valid_o), 32'd1);
      check_val("rd_rx_data", 32'(bus.rx_data_o), 32'(data_q[i]));
      bus.rx_ready_i = 1'b1;
      cycle(1);
      bus.rx_ready_i = 1'b0;
    end
    check_val("rd_rx_drained", 32'(bus.rx_valid_o), 32'd0);
  endtask

  // One-byte write issued with TX empty: must stall, then send the new byte.
  task automatic check_tx_empty(input string tag);
    int e0, lat;
    logic [I2C_BYTE_W-1:0] b;
    b  = 8'($urandom);
    e0 = en_cnt;
    send_cmd(7'h10, 1'b0, 8'd1);
    check_val({tag, "_nack_cleared"}, 32'(bus.nack_o), 32'd0);
    cycle(6);
    check_val({tag, "_stall"}, 32'(en_cnt - e0), 32'd0);
    push_tx(b);
    wait_enable(lat);
    check_val({tag, "_enable_seen"}, 32'(lat < 99), 32'd1);
    check_val({tag, "_data"}, 32'(bus.mst_wdata_o), 32'(b));
    check_val({tag, "_eow"}, 32'(bus.mst_eow_o), 32'd1);
    bus.mst_busy_i = 1'b1;
    pulse_byte_done(8'h00);
    end_xfer(tag);
  endtask

  initial begin
    logic [I2C_BYTE_W-1:0] q[$];
    logic [I2C_BYTE_W-1:0] b0, b1;
    int n, e0, d0, lat;
    logic [6:0] a;

    bus.cmd_valid_i      = 1'b0;
    bus.cmd_addr_i       = '0;
    bus.cmd_rw_i         = 1'b0;
    bus.cmd_len_i        = '0;
    bus.tx_valid_i       = 1'b0;
    bus.tx_data_i        = '0;
    bus.rx_ready_i       = 1'b0;
    bus.mst_byte_done_i  = 1'b0;
    bus.mst_rdata_i      = '0;
    bus.mst_slave_nack_i = 1'b0;
    bus.mst_busy_i       = 1'b0;

    cycle(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    cycle(2);

    q = {8'hAA, 8'hF0, 8'h28, 8'h55};
    do_write(7'h54, q);

    q = {8'h11, 8'h22, 8'h33};
    do_read(7'h2A, q);

    // Slave NACK after the first byte of a four-byte write.
    q = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    e0 = en_cnt;
    d0 = done_cnt;
    foreach (q[i]) push_tx(q[i]);
    send_cmd(7'h3C, 1'b0, 8'd4);
    wait_enable(lat);
    check_val("nk_latency", 32'(lat), 32'd2);
    bus.mst_busy_i = 1'b1;
    check_val("nk_data0", 32'(bus.mst_wdata_o), 32'(q[0]));
    pulse_byte_done(8'h00);
    cycle(1);
    bus.mst_slave_nack_i = 1'b1;
    cycle(1);
    bus.mst_slave_nack_i = 1'b0;
    check_val("nk_nack", 32'(bus.nack_o), 32'd1);
    check_val("nk_busy_state", 32'(bus.cmd_ready_o), 32'd0);
    end_xfer("nk");
    check_val("nk_nack_sticky", 32'(bus.nack_o), 32'd1);
    check_val("nk_enables", 32'(en_cnt - e0), 32'd1);
    check_val("nk_dones", 32'(done_cnt - d0), 32'd1);
    check_tx_empty("nk_tx");

    // Three-byte write started with TX empty; only two bytes ever arrive.
    e0 = en_cnt;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    send_cmd(7'h33, 1'b0, 8'd3);
    cycle(8);
    check_val("ur_stall", 32'(en_cnt - e0), 32'd0);
    push_tx(b0);
    wait_enable(lat);
    check_val("ur_enable_seen", 32'(lat < 99), 32'd1);
    bus.mst_busy_i = 1'b1;
    push_tx(b1);
    check_val("ur_data0", 32'(bus.mst_wdata_o), 32'(b0));
    check_val("ur_eow0", 32'(bus.mst_eow_o), 32'd0);
    pulse_byte_done(8'h00);
    check_val("ur_data1", 32'(bus.mst_wdata_o), 32'(b1));
    check_val("ur_eow1", 32'(bus.mst_eow_o), 32'd0);
    check_val("ur_nack_pre", 32'(bus.nack_o), 32'd0);
    pulse_byte_done(8'h00);
    check_val("ur_eow_forced", 32'(bus.mst_eow_o), 32'd1);
    check_val("ur_nack", 32'(bus.nack_o), 32'd1);
    check_val("ur_data_held", 32'(bus.mst_wdata_o), 32'(b1));
    pulse_byte_done(8'h00);
    end_xfer("ur");
    check_val("ur_enables", 32'(en_cnt - e0), 32'd1);

    // Zero-length command.
    e0 = en_cnt;
    send_cmd(7'h22, 1'b0, 8'd0);
    check_val("z_done", 32'(bus.done_o), 32'd1);
    cycle(1);
    check_val("z_done_pulse", 32'(bus.done_o), 32'd0);
    cycle(3);
    check_val("z_no_enable", 32'(en_cnt - e0), 32'd0);
    check_val("z_idle", 32'(bus.cmd_ready_o), 32'd1);

    // Asynchronous reset in the middle of a write.
    q = {8'($urandom), 8'($urandom), 8'($urandom)};
    foreach (q[i]) push_tx(q[i]);
    send_cmd(7'h7F, 1'b0, 8'd3);
    wait_enable(lat);
    bus.mst_busy_i = 1'b1;
    pulse_byte_done(8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    bus.mst_busy_i = 1'b0;
    cycle(1);
    rst_n = 1'b1;
    cycle(1);
    check_val("arst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check_tx_empty("arst_tx");

    // Random traffic against the byte-queue model.
    for (int k = 0; k < 14; k++) begin
      n = $urandom_range(1, DEPTH);
      a = 7'($urandom);
      q.delete();
      for (int j = 0; j < n; j++) q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 0) do_write(a, q);
      else do_read(a, q);
      cycle($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
